gnrl_fifo: RTL
==============

# gnrl_fifo

Synchronous valid/ready FIFO in the general library. It decouples a producer pipeline stage from a consumer stage, such as fetch→decode or an LSU response queue. Entry storage uses plain load-enable registers. Read/write pointers and the occupancy counter use resettable registers.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 4, number of entries; any integer ≥ 1
- CW, $clog2(DEPTH+1), width of `count`
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous clear of all entries; wins over push/pop
- i_vld  input  1  producer offers `i_dat`
- i_rdy  output  1  FIFO can accept; equals `!full`
- i_dat  input  WIDTH  write data
- o_vld  output  1  FIFO holds valid head data; equals `!empty` (see Configuration)
- o_rdy  input  1  consumer accepts head
- o_dat  output  WIDTH  head entry data
- count  output  CW  current occupancy, 0..DEPTH

## Operation
- Push = `i_vld & i_rdy`. Pop = `o_vld & o_rdy`.
- Storage is DEPTH×WIDTH, indexed by `wptr`/`rptr`, each 0..DEPTH-1.
  - Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
  - Storage is not reset; contents are X until written.
- `count` next value:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - `full = (count == DEPTH)`, `empty = (count == 0)`
- `o_dat` = `mem[rptr]`, combinational from registered state. No output register.
- Push when full is impossible because `i_rdy` = 0. Producer data is ignored and no state changes.
- Pop when empty is impossible because `o_vld` = 0. No state changes.
- Simultaneous push and pop when full:
  - `i_rdy` is 0, so only the pop occurs.
  - The freed slot is visible as `i_rdy` = 1 next cycle. There is no same-cycle ready-through.
- Simultaneous push and pop with 0 < count < DEPTH: both occur; `count` is unchanged and both pointers advance.
- `flush` = 1:
  - Next edge sets wptr = rptr = count = 0.
  - Any push or pop in that cycle is discarded. Handshake outputs still reflect pre-flush state that cycle.
- DEPTH = 1 degenerates to a single-entry half-rate buffer, with `i_rdy = !o_vld`.

## Timing
- Reset values: wptr = 0, rptr = 0, count = 0. Hence `o_vld` = 0, `i_rdy` = 1, `count` = 0.
- `o_dat` is undefined after reset until the first push.
- Reset mid-operation: all queued entries are lost immediately (asynchronously); outputs return to reset values.
- Write latency: data pushed at edge N is presented as `o_dat` with `o_vld` = 1 after edge N (one cycle).
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- `i_rdy` and `o_vld` depend only on registered state, with no combinational path from `i_vld`/`o_rdy`. The exception is `GNRL_FIFO_BYPASS_EN`.

## Configuration
- Macro `GNRL_FIFO_BYPASS_EN`.
- Defined: when count == 0 and `i_vld` = 1, the FIFO passes data straight through.
  - `o_vld` = 1 and `o_dat` = `i_dat` combinationally.
  - If `o_rdy` = 1, the item is consumed that cycle: no pointer or count change, zero latency.
  - If `o_rdy` = 0, the item is written normally.
  - This adds a combinational `i_vld`→`o_vld` and `i_dat`→`o_dat` path. `flush` suppresses the bypass (`o_vld` = 0 while flush = 1).
- Undefined: the one-cycle latency behaviour of Operation/Timing applies. Outputs are strictly state-derived.

## Test plan
- Reset, then idle → `o_vld` = 0, `i_rdy` = 1, `count` = 0. Assert `rst_n` low mid-stream with count = 3 → outputs return to reset values immediately.
- Fill/drain, DEPTH = 4, `o_rdy` = 0:
  - Push 0xA0..0xA3 → `count` = 4, `i_rdy` = 0. A fifth push of 0xA4 is ignored.
  - Then `o_rdy` = 1 for 4 cycles → `o_dat` sequence is 0xA0, 0xA1, 0xA2, 0xA3, then `o_vld` = 0.
- Wrap-around, DEPTH = 3: push/pop continuously for 10 items 1..10 with random `o_rdy` stalls → output order 1..10, no loss or duplication. `count` never exceeds 3.
- Simultaneous push/pop:
  - At count = 2 → count stays 2, and the head advances to the next item.
  - At count = DEPTH with `i_vld` = 1 → only the pop occurs; count = DEPTH−1 next cycle and `i_rdy` = 1.
- Flush with count = 3 and push asserted → next cycle count = 0, `o_vld` = 0. The pushed item never appears at the output.
- Bypass (with `GNRL_FIFO_BYPASS_EN`), count = 0, `i_vld` = `o_rdy` = 1, `i_dat` = 0x55 → same cycle `o_vld` = 1, `o_dat` = 0x55; count stays 0. Without the macro → `o_vld` = 0 that cycle, then 0x55 appears next cycle.

Source files
------------

// File: rtl/gnrl_fifo.sv
// -----------------------------------------------------------------------------
// gnrl_fifo -- synchronous valid/ready FIFO for the general library.
//
// Decouples a producer stage from a consumer stage. Storage is plain
// load-enable registers (not reset); pointers and the occupancy counter reset
// asynchronously. DEPTH may be any integer >= 1 (non-power-of-two supported).
//
// Optional feature macro: GNRL_FIFO_BYPASS_EN
//   defined   : when the FIFO is empty, an offered item is presented on the
//               output in the same cycle (combinational i_vld->o_vld and
//               i_dat->o_dat paths). If taken, nothing is stored.
//   undefined : outputs derive strictly from registered state; one-cycle
//               write-to-read latency.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high on that side (push = i_vld & i_rdy, pop = o_vld & o_rdy). Valid
// may not depend on ready; ready here depends only on registered state.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset
//   flush  in  1      synchronous clear, wins over push/pop
//   i_vld  in  1      producer offers i_dat
//   i_rdy  out 1      FIFO can accept (not full)
//   i_dat  in  WIDTH  write data
//   o_vld  out 1      head data valid
//   o_rdy  in  1      consumer accepts head
//   o_dat  out WIDTH  head data
//   count  out CW     occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module gnrl_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic [CW-1:0]    count
);

  // Pointer width; a single-entry FIFO still needs a 1-bit pointer that
  // simply stays at 0.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic full, empty;
  logic push, pop;
  logic push_st, pop_st;   // push/pop that actually touch stored state

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign i_rdy = !full;
  assign count = count_q;

`ifdef GNRL_FIFO_BYPASS_EN
  logic byp;
  // Pass-through only when nothing is queued and no flush is in progress.
  assign byp     = empty & i_vld & !flush;
  assign o_vld   = !empty | byp;
  assign o_dat   = byp ? i_dat : mem_q[rptr_q];
  assign push    = i_vld & i_rdy;
  assign pop     = o_vld & o_rdy;
  // A bypassed item that is consumed immediately is never stored.
  assign push_st = push & !(byp & o_rdy);
  assign pop_st  = pop & !byp;
`else
  assign o_vld   = !empty;
  assign o_dat   = mem_q[rptr_q];
  assign push    = i_vld & i_rdy;
  assign pop     = o_vld & o_rdy;
  assign push_st = push;
  assign pop_st  = pop;
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_st) wptr_d = ptr_inc(wptr_q);
      if (pop_st)  rptr_d = ptr_inc(rptr_q);
      if (push_st && !pop_st)      count_d = count_q + CW'(1);
      else if (pop_st && !push_st) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Data storage: load-enable only, no reset.
  always_ff @(posedge clk) begin
    if (push_st && !flush) mem_q[wptr_q] <= i_dat;
  end

endmodule
